neokeon_theta_iter: RTL and testbench
=====================================

// Module: neokeon_theta_iter
// PURPOSE
//  Iterative Neokeon Theta transform; direct consumer of the 32-bit ROTR8/ROTL8 rotate functions.
//  - Accepts a 128-bit state and a 128-bit working key over a valid/ready handshake.
//  - Computes Theta in two half-steps, one per clock. Each half-step uses one ROTR8/ROTL8 pair.
//  - Presents the result on a held valid/ready output. Sits between Gamma/Pi stages in the round datapath.
// PARAMETERS
//  WORD_W  32  state word width; only 32 is legal.
//  ROT     8   rotate amount passed to the ROTR/ROTL helper functions; only 8 is legal.
// PORTS
//  inClk        in   1    clock; all logic updates on its rising edge.
//  inRst        in   1    synchronous reset, active-high.
//  inValid      in   1    input state/key valid.
//  inReady      out  1    block can accept (high only in IDLE).
//  inState      in   128  state a0..a3; a0 = [127:96], a3 = [31:0].
//  inKey        in   128  working key k0..k3, same word order as inState.
//  outValid     out  1    outputData valid.
//  outReady     in   1    consumer accepts outputData.
//  outputData   out  128  Theta(state, key), same word order.
// BEHAVIOUR
//  - Reset: on inRst high at an edge, all of the following take effect that edge:
//    - state goes to IDLE;
//    - outValid=0, outputData=0, internal a0..a3 and key registers = 0.
//    - inReady is 1 in IDLE.
//    - Reset overrides any handshake at the same edge, including mid-computation.
//  - FSM IDLE -> H1 -> H2 -> DONE -> IDLE.
//    - IDLE: inReady=1. If inValid, latch inState/inKey and go to H1.
//    - H1: t = a0^a2; t ^= ROTR8(t)^ROTL8(t); a1 ^= t; a3 ^= t; then ai ^= ki for i=0..3. Go to H2.
//    - H2: t = a1^a3; t ^= ROTR8(t)^ROTL8(t); a0 ^= t; a2 ^= t. Register into outputData. Go to DONE.
//    - DONE: outValid=1. outputData is stable and must not change while outReady=0.
//      If outReady, go to IDLE with outValid=0 the next cycle.
//  - Latency: accept edge N -> outValid=1 after edge N+2. Maximum throughput is one result per 4 cycles.
//  - inReady=0 in H1, H2 and DONE. inValid is ignored in those states; there is no queuing.
//  - All XORs are 32-bit. Rotations wrap bits modulo 32; there is no carry or width growth.
//  - outputData keeps its last value in IDLE; only reset clears it.
//  - X-free: no output may be X after the first reset edge.
// CONFIGURATION
//  NEOKEON_THETA_NULLKEY_EN
//   - Defined: adds input port inNullKey (1 bit), sampled with inValid at accept.
//     If it is high, the latched key is 0 regardless of inKey. This provides Theta(K, 0) for decryption key derivation.
//   - Undefined: the port is absent and the key is always inKey.
//   - All other timing is identical in both builds.
// TESTING
//  T1 inState = 128'h00800080_0..0, inKey=0, outReady=1
//     -> outputData = 128'h00800080_00800080_00000000_00800080, outValid at accept+2.
//  T2 inState=0, inKey = 128'h00000000_01000000_00000000_00000000
//     -> outputData = 128'h01010001_01000000_01010001_00000000.
//  T3 outReady=0 for 3 cycles after outValid:
//     - outValid, outputData and inReady=0 all held;
//     - an inValid pulse during that time is ignored;
//     - outReady=1 -> IDLE next cycle.
//  T4 inRst asserted in H2 -> after that edge: IDLE, outValid=0, outputData=0, inReady=1.
//     Then T1 rerun gives T1's result.
//  T5 back-to-back inValid held high, 3 distinct states:
//     - exactly 3 results, in order, spaced 4 cycles;
//     - each result checked against a reference model.
//  T6 (NULLKEY_EN) T2 stimulus with inNullKey=1 -> outputData = 0.

Source files
------------

// File: rtl/neokeon_theta_iter.sv
// Iterative Neokeon Theta: two half-steps, one per clock, held valid/ready output.
// Optional build macro NEOKEON_THETA_NULLKEY_EN adds inNullKey to force a zero key.
module neokeon_theta_iter #(
    parameter int WORD_W = 32,
    parameter int ROT    = 8
) (
    input  logic                  inClk,
    input  logic                  inRst,
    input  logic                  inValid,
    output logic                  inReady,
    input  logic [4*WORD_W-1:0]   inState,
    input  logic [4*WORD_W-1:0]   inKey,
`ifdef NEOKEON_THETA_NULLKEY_EN
    input  logic                  inNullKey,
`endif
    output logic                  outValid,
    input  logic                  outReady,
    output logic [4*WORD_W-1:0]   outputData
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        H1   = 2'd1,
        H2   = 2'd2,
        DONE = 2'd3
    } state_t;

    typedef logic [WORD_W-1:0] word_t;

    function automatic word_t rotr(input word_t x);
        return (x >> ROT) | (x << (WORD_W - ROT));
    endfunction

    function automatic word_t rotl(input word_t x);
        return (x << ROT) | (x >> (WORD_W - ROT));
    endfunction

    function automatic word_t mix(input word_t t);
        return t ^ rotr(t) ^ rotl(t);
    endfunction

    state_t state;
    state_t state_nxt;

    word_t a [4];
    word_t k [4];

    logic [4*WORD_W-1:0] key_sel;
    word_t t1;
    word_t t2;

`ifdef NEOKEON_THETA_NULLKEY_EN
    assign key_sel = inNullKey ? '0 : inKey;
`else
    assign key_sel = inKey;
`endif

    // Theta mixing terms for each half-step, taken from the current word registers.
    always_comb begin
        t1 = mix(a[0] ^ a[2]);
        t2 = mix(a[1] ^ a[3]);
    end

    assign inReady  = (state == IDLE);
    assign outValid = (state == DONE);

    // State register; reset wins over any handshake at the same edge.
    always_ff @(posedge inClk) begin
        if (inRst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic: fixed walk IDLE -> H1 -> H2 -> DONE, leaving DONE on outReady.
    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE: if (inValid) state_nxt = H1;
            H1:   state_nxt = H2;
            H2:   state_nxt = DONE;
            DONE: if (outReady) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Word/key registers and the result register; outputData only moves in H2.
    always_ff @(posedge inClk) begin
        if (inRst) begin
            for (int i = 0; i < 4; i++) begin
                a[i] <= '0;
                k[i] <= '0;
            end
            outputData <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (inValid) begin
                        for (int i = 0; i < 4; i++) begin
                            a[i] <= inState[(3-i)*WORD_W +: WORD_W];
                            k[i] <= key_sel[(3-i)*WORD_W +: WORD_W];
                        end
                    end
                end
                H1: begin
                    a[0] <= a[0] ^ k[0];
                    a[1] <= a[1] ^ t1 ^ k[1];
                    a[2] <= a[2] ^ k[2];
                    a[3] <= a[3] ^ t1 ^ k[3];
                end
                H2: begin
                    outputData <= {a[0] ^ t2, a[1], a[2] ^ t2, a[3]};
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_neokeon_theta_iter.sv
// Scoreboard bench for neokeon_theta_iter with a word-level Theta reference model.
module tb_neokeon_theta_iter;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [127:0] in_state;
    logic [127:0] in_key;
`ifdef NEOKEON_THETA_NULLKEY_EN
    logic         null_key;
`endif
    logic         out_valid;
    logic         out_ready;
    logic [127:0] out_data;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;
    logic rnd_bp = 1'b0;

    logic [127:0] exp_q [$];
    int           hs_q  [$];

    neokeon_theta_iter dut (
        .inClk      (clk),
        .inRst      (rst),
        .inValid    (in_valid),
        .inReady    (in_ready),
        .inState    (in_state),
        .inKey      (in_key),
`ifdef NEOKEON_THETA_NULLKEY_EN
        .inNullKey  (null_key),
`endif
        .outValid   (out_valid),
        .outReady   (out_ready),
        .outputData (out_data)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [31:0] ror(input logic [31:0] x, input int n);
        return (x >> n) | (x << (32 - n));
    endfunction

    function automatic logic [31:0] rol(input logic [31:0] x, input int n);
        return (x << n) | (x >> (32 - n));
    endfunction

    function automatic logic [127:0] theta_ref(input logic [127:0] s,
                                               input logic [127:0] k);
        logic [31:0] a [4];
        logic [31:0] kw [4];
        logic [31:0] t;
        for (int i = 0; i < 4; i++) begin
            a[i]  = s[127-32*i -: 32];
            kw[i] = k[127-32*i -: 32];
        end
        t = a[0] ^ a[2];
        t = t ^ ror(t, 8) ^ rol(t, 8);
        a[1] = a[1] ^ t;
        a[3] = a[3] ^ t;
        for (int i = 0; i < 4; i++) a[i] = a[i] ^ kw[i];
        t = a[1] ^ a[3];
        t = t ^ ror(t, 8) ^ rol(t, 8);
        a[0] = a[0] ^ t;
        a[2] = a[2] ^ t;
        return {a[0], a[1], a[2], a[3]};
    endfunction

    task automatic check(input string name, input logic [127:0] act,
                         input logic [127:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    // Monitor: every accepted output beat is compared with the oldest expectation.
    always @(negedge clk) begin
        if (!rst && out_valid && out_ready) begin
            hs_q.push_back(cyc);
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_result actual=%h required=none", out_data);
            end else begin
                check("result", out_data, exp_q.pop_front());
            end
        end
    end

    // Random backpressure driver, active only while rnd_bp is set.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (rnd_bp) out_ready = 1'($urandom_range(0, 1));
        end
    end

    // Presents a transaction and returns #1 after its accept edge, inValid still high.
    task automatic send(input logic [127:0] s, input logic [127:0] k,
                        input logic nk);
        int n = 0;
        in_state = s;
        in_key   = k;
`ifdef NEOKEON_THETA_NULLKEY_EN
        null_key = nk;
`endif
        in_valid = 1'b1;
        @(negedge clk);
        while (!in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) begin
            checks++;
            failures++;
            $display("FAIL accept_timeout actual=0 required=1");
        end
`ifdef NEOKEON_THETA_NULLKEY_EN
        exp_q.push_back(theta_ref(s, nk ? 128'h0 : k));
`else
        exp_q.push_back(theta_ref(s, k));
`endif
        @(posedge clk);
        #1;
    endtask

    task automatic drain();
        int n = 0;
        while (exp_q.size() > 0 && n < 200) begin
            @(posedge clk);
            n++;
        end
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL drain_timeout actual=%0d required=0", exp_q.size());
        end
        @(posedge clk);
        #1;
    endtask

    localparam logic [127:0] T1_S = 128'h00800080_00000000_00000000_00000000;
    localparam logic [127:0] T1_R = 128'h00800080_00800080_00000000_00800080;
    localparam logic [127:0] T2_K = 128'h00000000_01000000_00000000_00000000;
    localparam logic [127:0] T2_R = 128'h01010001_01000000_01010001_00000000;

    initial begin
        logic [127:0] held;
        logic [127:0] s;
        logic [127:0] k;
        int n;
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_state  = '0;
        in_key    = '0;
`ifdef NEOKEON_THETA_NULLKEY_EN
        null_key  = 1'b0;
`endif
        out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("rst_out_valid", 128'(out_valid), 128'd0);
        check("rst_out_data", out_data, 128'd0);
        check("rst_in_ready", 128'(in_ready), 128'd1);

        // Reference model sanity against the hand-computed vectors.
        check("model_t1", theta_ref(T1_S, 128'h0), T1_R);
        check("model_t2", theta_ref(128'h0, T2_K), T2_R);

        // T1 with latency check.
        @(posedge clk);
        #1;
        send(T1_S, 128'h0, 1'b0);
        in_valid = 1'b0;
        check("t1_valid_h1", 128'(out_valid), 128'd0);
        @(posedge clk);
        #1;
        check("t1_valid_h2", 128'(out_valid), 128'd0);
        @(posedge clk);
        #1;
        check("t1_valid_done", 128'(out_valid), 128'd1);
        check("t1_data", out_data, T1_R);
        drain();

        // T2.
        send(128'h0, T2_K, 1'b0);
        in_valid = 1'b0;
        drain();
        check("t2_data", out_data, T2_R);
        check("t2_data_kept_idle", 128'(in_ready), 128'd1);

        // T3: backpressure hold and ignored inValid.
        out_ready = 1'b0;
        s = {$urandom, $urandom, $urandom, $urandom};
        k = {$urandom, $urandom, $urandom, $urandom};
        send(s, k, 1'b0);
        in_valid = 1'b0;
        n = 0;
        @(negedge clk);
        while (!out_valid && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("t3_valid_seen", 128'(out_valid), 128'd1);
        held = out_data;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            if (i == 1) begin
                in_state = ~s;
                in_valid = 1'b1;
            end
            if (i == 2) in_valid = 1'b0;
            @(negedge clk);
            check("t3_hold_valid", 128'(out_valid), 128'd1);
            check("t3_hold_data", out_data, held);
            check("t3_hold_in_ready", 128'(in_ready), 128'd0);
        end
        @(posedge clk);
        #1 out_ready = 1'b1;
        @(posedge clk);
        #1;
        check("t3_idle_in_ready", 128'(in_ready), 128'd1);
        check("t3_idle_out_valid", 128'(out_valid), 128'd0);
        drain();

        // T4: reset during H2, then rerun T1.
        send(T1_S, 128'h0, 1'b0);
        in_valid = 1'b0;
        @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        exp_q.delete();
        check("t4_out_valid", 128'(out_valid), 128'd0);
        check("t4_out_data", out_data, 128'd0);
        check("t4_in_ready", 128'(in_ready), 128'd1);
        send(T1_S, 128'h0, 1'b0);
        in_valid = 1'b0;
        drain();
        check("t4_rerun", out_data, T1_R);

        // T5: back-to-back with inValid held high.
        hs_q.delete();
        for (int i = 0; i < 3; i++) begin
            send({$urandom, $urandom, $urandom, $urandom},
                 {$urandom, $urandom, $urandom, $urandom}, 1'b0);
        end
        in_valid = 1'b0;
        drain();
        repeat (4) @(posedge clk);
        #1;
        check("t5_count", 128'(hs_q.size()), 128'd3);
        if (hs_q.size() == 3) begin
            check("t5_gap1", 128'(hs_q[1] - hs_q[0]), 128'd4);
            check("t5_gap2", 128'(hs_q[2] - hs_q[1]), 128'd4);
        end

`ifdef NEOKEON_THETA_NULLKEY_EN
        // T6: null key forces Theta(state, 0).
        send(128'h0, T2_K, 1'b1);
        in_valid = 1'b0;
        drain();
        check("t6_nullkey", out_data, 128'h0);
`endif

        // Random transactions under random backpressure.
        rnd_bp = 1'b1;
        for (int i = 0; i < 20; i++) begin
            send({$urandom, $urandom, $urandom, $urandom},
                 {$urandom, $urandom, $urandom, $urandom},
                 1'($urandom_range(0, 1)));
            if ($urandom_range(0, 1) == 1) in_valid = 1'b0;
        end
        in_valid = 1'b0;
        rnd_bp = 1'b0;
        @(posedge clk);
        #2 out_ready = 1'b1;
        drain();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
